// File: rtl/pixel_word_packer_if.sv
`default_nettype none
// ============================================================================
// pixel_word_packer_if : byte-in / word-out handshake bundle of the packer
// Revision: 1.0
// ============================================================================
interface pixel_word_packer_if #(
    parameter int WORD_WIDTH = 128
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  frame_done;
    logic [15:0]           frame_count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_done, frame_count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_done, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/pixel_word_packer.sv
`default_nettype none
// ============================================================================
// pixel_word_packer : packs a UART byte stream into pixels, then into DDR words
// Revision: 1.0
// ============================================================================
module pixel_word_packer #(
    parameter int BYTES_PER_PIXEL = 3,
    parameter int PIXELS_PER_WORD = 5,
    parameter int WORD_WIDTH      = 128,
    parameter int FRAME_PIXELS    = 786432
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pixel_word_packer_if.slave bus
);
    localparam int PIX_W  = 8 * BYTES_PER_PIXEL;
    localparam int PACK_W = PIXELS_PER_WORD * PIX_W;
    localparam int BW     = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int PW     = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
    localparam int FW     = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    generate
        if (PACK_W > WORD_WIDTH) begin : g_width_check
            $error("pixel_word_packer: PIXELS_PER_WORD*BYTES_PER_PIXEL*8 exceeds WORD_WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [PW-1:0]         pix_idx_q, pix_idx_d;
    logic [FW-1:0]         frame_pix_q, frame_pix_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [PACK_W-1:0]     acc_q, acc_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  frame_done_q, frame_done_d;
    logic [15:0]           frame_count_q, frame_count_d;

    logic              w_pix_done;
    logic              w_frame_end;
    logic              w_completing;
    logic              w_out_free;
    logic              w_in_ready;
    logic              w_accept;
    logic [PIX_W-1:0]  w_pix_next;
    logic [PACK_W-1:0] w_acc_fill;

    always_comb begin
        w_pix_done   = (byte_idx_q == BW'(BYTES_PER_PIXEL - 1));
        w_frame_end  = (frame_pix_q == FW'(FRAME_PIXELS - 1));
        w_completing = w_pix_done && ((pix_idx_q == PW'(PIXELS_PER_WORD - 1)) || w_frame_end);
        w_out_free   = !out_valid_q || bus.out_ready;
        w_in_ready   = (state_q == S_ACCUM) && !(w_completing && !w_out_free);
        w_accept     = bus.in_valid && w_in_ready;
        // First byte of a pixel ends up in the MSBs after BPP shifts.
        w_pix_next   = PIX_W'({pix_q, bus.in_data});
        w_acc_fill   = acc_q;
        w_acc_fill[int'(pix_idx_q) * PIX_W +: PIX_W] = w_pix_next;
    end

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        pix_idx_d     = pix_idx_q;
        frame_pix_d   = frame_pix_q;
        pix_d         = pix_q;
        acc_d         = acc_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d  = 1'b0;
            frame_done_d = out_last_q;
            if (out_last_q) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end

        case (state_q)
            S_ACCUM: begin
                if (w_accept) begin
                    pix_d = w_pix_next;
                    if (w_pix_done) begin
                        byte_idx_d  = '0;
                        frame_pix_d = w_frame_end ? '0 : frame_pix_q + 1'b1;
                        if (w_completing) begin
                            out_valid_d = 1'b1;
                            out_data_d  = WORD_WIDTH'(w_acc_fill);
                            out_last_d  = w_frame_end;
                            acc_d       = '0;
                            pix_idx_d   = '0;
                        end else begin
                            acc_d     = w_acc_fill;
                            pix_idx_d = pix_idx_q + 1'b1;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
                // A flush colliding with a word-completing byte is redundant.
                if (bus.flush && !(w_accept && w_completing)) begin
                    byte_idx_d = '0;
                    if (pix_idx_d != '0) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = WORD_WIDTH'(acc_q);
                    out_last_d  = 1'b0;
                    acc_d       = '0;
                    pix_idx_d   = '0;
                    state_d     = S_ACCUM;
                end
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_ACCUM;
            byte_idx_q    <= '0;
            pix_idx_q     <= '0;
            frame_pix_q   <= '0;
            pix_q         <= '0;
            acc_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            pix_idx_q     <= pix_idx_d;
            frame_pix_q   <= frame_pix_d;
            pix_q         <= pix_d;
            acc_q         <= acc_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
endmodule
`default_nettype wire

// File: tb/tb_pixel_word_packer.sv
`default_nettype none
// ============================================================================
// tb_pixel_word_packer : directed and random stimulus against a pixel/word model
// Revision: 1.0
// ============================================================================
module tb_pixel_word_packer;
    localparam int BPP = 3;
    localparam int PPW = 5;
    localparam int WW  = 128;
    localparam int FP  = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pixel_word_packer_if #(.WORD_WIDTH(WW)) bus ();

    pixel_word_packer #(
        .BYTES_PER_PIXEL(BPP),
        .PIXELS_PER_WORD(PPW),
        .WORD_WIDTH     (WW),
        .FRAME_PIXELS   (FP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
    } word_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  m_bytes[$];
    logic [23:0] m_pixels[$];
    word_t       m_q[$];
    int          m_fpix;
    int          m_fcount;
    bit          m_fpend;
    bit          m_done;
    bit          m_accepted;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_bytes.delete();
        m_pixels.delete();
        m_q.delete();
        m_fpix   = 0;
        m_fcount = 0;
        m_fpend  = 0;
        m_done   = 0;
    endtask

    task automatic push_word(input bit last);
        word_t w;
        w.data = '0;
        for (int k = 0; k < m_pixels.size(); k++) w.data[k*24 +: 24] = m_pixels[k];
        w.last = last;
        m_q.push_back(w);
        m_pixels.delete();
    endtask

    task automatic check_outputs();
        check("out_valid", bus.out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("out_data", bus.out_data, m_q[0].data);
            check("out_last", bus.out_last, m_q[0].last);
        end
        check("frame_done", bus.frame_done, m_done);
        check("frame_count", bus.frame_count, m_fcount[15:0]);
    endtask

    // Drive one cycle from a negedge, advance the model, check at the next negedge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic fl, input logic ordy);
        bit          completing, exp_rdy, hs, frame_last;
        logic [23:0] pixel;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        completing = (m_bytes.size() == BPP - 1) &&
                     ((m_pixels.size() == PPW - 1) || (m_fpix == FP - 1));
        exp_rdy = !m_fpend && !(completing && m_q.size() != 0 && !ordy);
        check("in_ready", bus.in_ready, exp_rdy);
        hs     = (m_q.size() != 0) && ordy;
        m_done = hs && m_q[0].last;
        if (hs) begin
            if (m_q[0].last) m_fcount++;
            void'(m_q.pop_front());
        end
        m_accepted = 0;
        if (m_fpend) begin
            if (m_q.size() == 0) begin
                push_word(1'b0);
                m_fpend = 0;
            end
        end else begin
            if (v && exp_rdy) begin
                m_accepted = 1;
                m_bytes.push_back(d);
                if (m_bytes.size() == BPP) begin
                    pixel = '0;
                    foreach (m_bytes[i]) pixel = (pixel << 8) | 24'(m_bytes[i]);
                    m_bytes.delete();
                    m_pixels.push_back(pixel);
                    frame_last = (m_fpix == FP - 1);
                    m_fpix     = frame_last ? 0 : m_fpix + 1;
                    if (m_pixels.size() == PPW || frame_last) push_word(frame_last);
                end
            end
            if (fl && !(m_accepted && completing)) begin
                m_bytes.delete();
                if (m_pixels.size() > 0) m_fpend = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ordy);
        for (int t = 0; t < 64; t++) begin
            cycle(1'b1, d, 1'b0, ordy);
            if (m_accepted) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_byte timeout: byte %h never accepted, expected acceptance within 64 cycles", d);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_frame_count", bus.frame_count, 16'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Basic word: bytes 01..0F
        do_reset();
        for (int i = 1; i <= 15; i++) send_byte(8'(i), 1'b1);
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_slot0", bus.out_data[23:0], 24'h010203);
        check("t1_slot4", bus.out_data[119:96], 24'h0D0E0F);
        check("t1_pad", bus.out_data[127:120], 8'h00);
        check("t1_last", bus.out_last, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: held word, 14 bytes accepted, 15th stalls
        do_reset();
        for (int i = 1; i <= 29; i++) send_byte(8'(i), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd30;
        #1;
        check("t2_blocked", bus.in_ready, 1'b0);
        cycle(1'b1, 8'd30, 1'b0, 1'b0);
        cycle(1'b1, 8'd30, 1'b0, 1'b0);
        check("t2_held", bus.out_data[23:0], 24'h010203);
        send_byte(8'd30, 1'b1);
        check("t2_word2", bus.out_data[23:0], 24'h101112);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Frame end: 12 pixels -> 5 + 5 + 2(last)
        do_reset();
        for (int i = 1; i <= 36; i++) send_byte(8'(i), 1'b1);
        check("t3_last", bus.out_last, 1'b1);
        check("t3_data", bus.out_data, 128'h222324_1F2021);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_done", bus.frame_done, 1'b1);
        check("t3_count", bus.frame_count, 16'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_done_pulse", bus.frame_done, 1'b0);

        // Flush after 7 bytes
        do_reset();
        for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_valid", bus.out_valid, 1'b1);
        check("t4_data", bus.out_data, 128'h040506_010203);
        check("t4_last", bus.out_last, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b1);
        for (int i = 0; i < 12; i++) send_byte(8'(8'hB0 + i), 1'b1);
        check("t4_next_slot0", bus.out_data[23:0], 24'hA1A2A3);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Flush while a word is held
        do_reset();
        for (int i = 1; i <= 18; i++) send_byte(8'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
        check("t5_stalled", bus.in_ready, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_valid", bus.out_valid, 1'b1);
        check("t5_data", bus.out_data, 128'h101112);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-word
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        do_reset();
        for (int i = 0; i < 15; i++) send_byte(8'(8'h40 + i), 1'b1);
        check("t6_slot0", bus.out_data[23:0], 24'h404142);
        check("t6_slot4", bus.out_data[119:96], 24'h4C4D4E);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                logic fl, v, ordy;
                fl   = ($urandom_range(39) == 0);
                v    = !fl && ($urandom_range(3) != 0);
                ordy = ($urandom_range(2) != 0);
                cycle(v, 8'($urandom), fl, ordy);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
